// File: rtl/normalize32_if.sv
// Start/done handshake and result bus shared by
// the sequencer and the iterative normalizer.
interface normalize32_if;
  logic        ready;
  logic        signed_mode;
  logic [31:0] in;
  logic        done;
  logic [31:0] out;
  logic [5:0]  count;
  logic        zero;

  modport master (
    output ready, signed_mode, in,
    input  done, out, count, zero
  );

  modport slave (
    input  ready, signed_mode, in,
    output done, out, count, zero
  );
endinterface

// File: rtl/normalize32.sv
// Iterative 32-bit left normalizer: one shift per
// cycle until the leading significant bit is on top.
module normalize32 (
  input  logic         clk,
  input  logic         reset,
  normalize32_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic sm_q;
  logic norm;
  logic stop;
  logic capture;
  logic shift;

  assign norm = sm_q ? (bus.out[31] ^ bus.out[30])
                     : bus.out[31];

  assign stop = bus.zero | norm
              | (bus.count == 6'd31);

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    shift    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ready) begin
          capture  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (stop) state_nx = DONE;
        else      shift    = 1'b1;
      end
      DONE: begin
        state_nx = bus.ready ? WAIT : IDLE;
      end
      WAIT: begin
        if (!bus.ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // done is registered off DONE, so it lands the
  // cycle after the final RUN decision edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out   <= 32'd0;
      bus.count <= 6'd0;
      bus.zero  <= 1'b0;
      bus.done  <= 1'b0;
      sm_q      <= 1'b0;
    end else begin
      bus.done <= (state == DONE);
      if (capture) begin
        bus.out   <= bus.in;
        bus.count <= 6'd0;
        bus.zero  <= (bus.in == 32'd0);
        sm_q      <= bus.signed_mode;
      end else if (shift) begin
        bus.out   <= {bus.out[30:0], 1'b0};
        bus.count <= bus.count + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_normalize32.sv
// Self-checking bench for normalize32: vector
// table plus hand-built handshake/reset sequences.
`timescale 1ns/1ps
module tb_normalize32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  normalize32_if bus ();

  normalize32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sm;
    logic [31:0] in;
    logic [31:0] out;
    logic [5:0]  count;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic [5:0]  count;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.out   = v.out;
    e.count = v.count;
    e.zero  = v.zero;
    e.lat   = 2 + int'(v.count);
    sb.push_back(e);
  endtask

  // drive a start; returns just after the accept edge
  task automatic start(input vec_t v);
    bus.ready       = 1'b1;
    bus.signed_mode = v.sm;
    bus.in          = v.in;
    tick();
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic score(input string name,
                       input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({name, " latency"}, lat, e.lat);
    check({name, " out"}, bus.out, e.out);
    check({name, " count"}, 32'(bus.count),
          32'(e.count));
    check({name, " zero"}, 32'(bus.zero),
          32'(e.zero));
  endtask

  task automatic run_vec(input vec_t v,
                         input string name);
    int lat;
    push(v);
    start(v);
    bus.ready       = 1'b0;
    bus.in          = $urandom;
    bus.signed_mode = ~v.sm;
    wait_done(lat);
    score(name, lat);
    tick();
    check({name, " done_1cyc"}, 32'(bus.done), 32'd0);
    check({name, " out_hold"}, bus.out, v.out);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t va;
    vec_t vb;
    int   lat;

    vecs[0]  = '{1'b0, 32'h0001_0000, 32'h8000_0000, 6'd15, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0001, 32'h8000_0000, 6'd31, 1'b0};
    vecs[2]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 6'd0,  1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 6'd0,  1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 6'd0,  1'b1};
    vecs[5]  = '{1'b1, 32'hFFFF_8000, 32'h8000_0000, 6'd16, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0001, 32'h4000_0000, 6'd30, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 6'd31, 1'b0};
    vecs[8]  = '{1'b1, 32'h4000_0000, 32'h4000_0000, 6'd0,  1'b0};
    vecs[9]  = '{1'b1, 32'hC000_0000, 32'h8000_0000, 6'd1,  1'b0};
    vecs[10] = '{1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 6'd1,  1'b0};

    reset           = 1'b1;
    bus.ready       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.in          = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst done", 32'(bus.done), 32'd0);
    check("rst out", bus.out, 32'd0);
    check("rst count", 32'(bus.count), 32'd0);
    check("rst zero", 32'(bus.zero), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("idle out", bus.out, 32'd0);
    check("idle done", 32'(bus.done), 32'd0);

    for (int i = 0; i < 11; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // ready held high across two operations
    va = vecs[0];
    vb = vecs[6];
    push(va);
    start(va);
    bus.in          = vb.in;
    bus.signed_mode = vb.sm;
    wait_done(lat);
    score("hold_a", lat);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wait done", 32'(bus.done), 32'd0);
      check("wait out", bus.out, va.out);
      check("wait count", 32'(bus.count),
            32'(va.count));
    end
    bus.ready = 1'b0;
    tick();
    push(vb);
    start(vb);
    bus.ready = 1'b0;
    wait_done(lat);
    score("hold_b", lat);
    tick();
    check("hold_b done_1cyc", 32'(bus.done), 32'd0);

    // reset in the 5th RUN cycle of 0x10
    va = '{1'b0, 32'h0000_0010, 32'h8000_0000, 6'd27, 1'b0};
    start(va);
    bus.ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst count", 32'(bus.count), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst done", 32'(bus.done), 32'd0);
    check("mid_rst out", bus.out, 32'd0);
    check("mid_rst count", 32'(bus.count), 32'd0);
    check("mid_rst zero", 32'(bus.zero), 32'd0);
    run_vec(va, "post_rst");

    check("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
